// File: rtl/ret_shadow_stack.sv
// ret_shadow_stack: return-address shadow stack fed by the branch unit's resolve strobe.
// Calls push the plain link address, returns pop it and compare it with the resolved
// target. A mismatch, or an unverifiable return on an empty stack with no lost frames,
// raises a one-cycle violation pulse and a sticky crash request (when enforcement is on).
// Overflow overwrites the oldest entry circularly and is counted in lost_o, so returns
// into discarded frames can pass unchecked instead of faulting.
// VLEN defaults to 64, the Sv39/64-bit core virtual address width (riscv::VLEN).

module ret_shadow_stack #(
    parameter int DEPTH = 16,
    parameter int VLEN  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     en_i,
    input  logic                     valid_i,
    input  logic                     is_call_i,
    input  logic                     is_ret_i,
    input  logic [VLEN-1:0]          link_addr_i,
    input  logic [VLEN-1:0]          target_i,
    output logic                     violation_o,
    output logic                     crash_o,
    output logic [$clog2(DEPTH):0]   depth_o,
    output logic [$clog2(DEPTH):0]   lost_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] STEP_C  = PW'(1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_ALARM = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic [VLEN-1:0]   stack_r [DEPTH];
    logic [PW-1:0]     top_r;
    logic [CW-1:0]     depth_r;
    logic [CW-1:0]     lost_r;
    logic              violation_r;
    logic              crash_r;

    logic [PW-1:0]     top_nxt_s;
    logic [CW-1:0]     depth_nxt_s;
    logic [CW-1:0]     lost_nxt_s;
    logic              wr_en_s;
    logic [PW-1:0]     wr_idx_s;
    logic              event_s;
    logic              mismatch_s;
    logic              viol_s;
    logic              viol_raise_s;

    // Events are only accepted while running; ALARM freezes all tracking state.
    assign event_s      = valid_i && (state_r == ST_RUN);
    assign mismatch_s   = (stack_r[top_r] != target_i);
    assign viol_raise_s = viol_s && en_i;

    // Stack bookkeeping: pointer, depth, lost counter, array write and violation detect.
    always_comb begin
        top_nxt_s   = top_r;
        depth_nxt_s = depth_r;
        lost_nxt_s  = lost_r;
        wr_en_s     = 1'b0;
        wr_idx_s    = top_r;
        viol_s      = 1'b0;

        if (flush_i) begin
            // Flush beats any same-cycle event; the pointer position is irrelevant once empty.
            depth_nxt_s = ZERO_C;
            lost_nxt_s  = ZERO_C;
        end else if (event_s) begin
            // Return half: check against the current top, or account for an empty stack.
            if (is_ret_i) begin
                if (depth_r != ZERO_C) begin
                    viol_s = mismatch_s;
                end else if (lost_r != ZERO_C) begin
                    lost_nxt_s = lost_r - ONE_C;
                end else begin
                    viol_s = 1'b1;
                end
            end else begin
                viol_s = 1'b0;
            end

            if (is_call_i && is_ret_i) begin
                // Coroutine swap: replace the checked frame, or push into an empty stack.
                if (depth_r != ZERO_C) begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = top_r;
                end else begin
                    wr_en_s     = 1'b1;
                    wr_idx_s    = top_r + STEP_C;
                    top_nxt_s   = top_r + STEP_C;
                    depth_nxt_s = ONE_C;
                end
            end else if (is_call_i) begin
                wr_en_s   = 1'b1;
                wr_idx_s  = top_r + STEP_C;
                top_nxt_s = top_r + STEP_C;
                if (depth_r == DEPTH_C) begin
                    // Full: the write overwrote the oldest frame; remember that it is gone.
                    if (lost_r != DEPTH_C) begin
                        lost_nxt_s = lost_r + ONE_C;
                    end else begin
                        lost_nxt_s = lost_r;
                    end
                end else begin
                    depth_nxt_s = depth_r + ONE_C;
                end
            end else if (is_ret_i) begin
                if (depth_r != ZERO_C) begin
                    top_nxt_s   = top_r - STEP_C;
                    depth_nxt_s = depth_r - ONE_C;
                end else begin
                    top_nxt_s   = top_r;
                end
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // FSM next state: a raised violation latches ALARM until flush.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (flush_i) begin
                    state_nxt_s = ST_RUN;
                end else if (viol_raise_s) begin
                    state_nxt_s = ST_ALARM;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (flush_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_ALARM;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pointer and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            top_r   <= {PW{1'b0}};
            depth_r <= ZERO_C;
            lost_r  <= ZERO_C;
        end else begin
            top_r   <= top_nxt_s;
            depth_r <= depth_nxt_s;
            lost_r  <= lost_nxt_s;
        end
    end

    // Return-address array; contents are meaningful only below depth, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            stack_r[wr_idx_s] <= link_addr_i;
        end
    end

    // Registered alarm outputs: one-cycle violation pulse and sticky crash request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            violation_r <= 1'b0;
            crash_r     <= 1'b0;
        end else if (flush_i) begin
            violation_r <= 1'b0;
            crash_r     <= 1'b0;
        end else begin
            violation_r <= viol_raise_s;
            crash_r     <= (state_nxt_s == ST_ALARM);
        end
    end

    assign violation_o = violation_r;
    assign crash_o     = crash_r;
    assign depth_o     = depth_r;
    assign lost_o      = lost_r;

endmodule

// File: doc/ret_shadow_stack.md
# ret_shadow_stack

Hardware return-address shadow stack that sits directly downstream of `branch_unit` in the execute stage. It consumes each resolved control-flow instruction. Calls push the plain (unencoded) link address; returns pop it and compare it against the resolved return target. A mismatch, or a return with nothing recorded, raises a sticky crash request. The frontend uses that request to redirect to the trap address.

## Interface
Parameters:
- `DEPTH`, 16, number of stack entries; power of two, ≥2
- `VLEN`, `riscv::VLEN`, address width

Ports:
- `clk_i`  in  1  core clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `flush_i`  in  1  clear stack, counters and alarm (context switch / debug entry)
- `en_i`  in  1  enforcement enable; when low, tracking continues but no violation is raised
- `valid_i`  in  1  one resolved control-flow instruction this cycle (branch unit resolve strobe)
- `is_call_i`  in  1  JAL/JALR with rd = x1
- `is_ret_i`  in  1  JALR with rd = x0, rs1 = x1
- `link_addr_i`  in  VLEN  plain next_pc of the instruction (pc+2 or pc+4)
- `target_i`  in  VLEN  resolved, decoded jump target
- `violation_o`  out  1  one-cycle pulse on a detected violation
- `crash_o`  out  1  sticky crash request
- `depth_o`  out  $clog2(DEPTH)+1  valid entries currently held
- `lost_o`  out  $clog2(DEPTH)+1  entries discarded by overflow, saturating at DEPTH

## Operation
- Storage: DEPTH×VLEN register array plus a circular top pointer, `depth_o` and `lost_o`.
- FSM states: RUN and ALARM.
  - Reset and flush both enter RUN.
  - RUN→ALARM on a violation while `en_i`=1.
  - ALARM→RUN only on `flush_i` or reset.
- An event requires `valid_i`=1. With `valid_i`=0, `is_call_i`/`is_ret_i` are ignored.
- Pure call:
  - Write `link_addr_i` at top+1 and advance top.
  - If `depth_o`==DEPTH, the oldest entry is overwritten, depth stays DEPTH, and `lost_o` increments (saturating).
  - Otherwise `depth_o` increments.
- Pure return, `depth_o`>0:
  - Pop: top retreats and `depth_o` decrements.
  - Violation if `target_i` != popped entry (all VLEN bits compared).
- Pure return, `depth_o`==0:
  - If `lost_o`>0, decrement `lost_o` with no check (unverifiable frame).
  - Otherwise, violation (return without call).
- Call and return together (JALR x1,x1, coroutine swap):
  - Compare against the current top exactly as for a pure return.
  - Then overwrite the top entry with `link_addr_i`; depth is unchanged.
  - If depth was 0, handle the return as an empty-stack return, then push into the empty stack (depth becomes 1).
- Violation with `en_i`=0: state and pop proceed, but no pulse and no ALARM.
- In ALARM: stack, `depth_o` and `lost_o` are frozen, and further events are ignored.
- `flush_i` has priority over any same-cycle event: the event is discarded and the stack is emptied.

## Timing
- Reset values:
  - `violation_o`=0, `crash_o`=0, `depth_o`=0, `lost_o`=0
  - FSM = RUN; array contents don't-care.
- All outputs are registered.
- Compare is combinational against the top entry in the event cycle.
- `violation_o` and `crash_o` rise on the edge ending the event cycle, i.e. visible one cycle after `valid_i`.
- `violation_o` lasts exactly one cycle.
- `crash_o` holds until flush or reset.
- Throughput: one event per cycle, back-to-back.
- A push in cycle N is poppable by a return in cycle N+1 (no bypass needed beyond the registered array).
- Asynchronous reset mid-sequence clears everything immediately. Flush takes effect at the next edge.

## Test plan
- Calls from link 0x80000104 then 0x80000210, returns to 0x80000210 then 0x80000104 → no violation; `depth_o` goes 1,2,1,0.
- Call with link 0x80000104, return with target 0x80000300 → `violation_o` is a single pulse one cycle later, `crash_o` stays 1. A subsequent call leaves `depth_o` at 0. `flush_i` clears `crash_o`.
- Return on empty stack with `lost_o`=0 → violation.
- DEPTH+2 calls (18 with DEPTH=16), then 18 matching returns → no violation. `lost_o` reads 2 after the calls. The last two returns are unchecked and `lost_o` ends at 0.
- Same sequence as the mismatch scenario with `en_i`=0 → no pulse, `crash_o`=0, `depth_o` back to 0.
- Call/return together with top 0x80000104, target 0x80000104, link 0x80000500 → no violation, depth unchanged. The next return to 0x80000500 passes.
- `flush_i` asserted together with a call → `depth_o`=0 next cycle.
